// File: rtl/pe_lin.sv
// Holds no module of its own; the driver and its FIFO live in their own files.
package pe_lin_unused_pkg;
endpackage

// File: rtl/pe_lin_pkg.sv
// Shared definitions for the PE_Lin driver: default widths/latency/depth and the FSM state type.
package pe_lin_pkg;

  localparam int unsigned DefDw       = 8;   // activation/weight width
  localparam int unsigned DefOw       = 12;  // PE output width
  localparam int unsigned DefLat      = 4;   // fire-to-output latency of PE_Lin
  localparam int unsigned DefResDepth = 8;   // result FIFO entries

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } state_e;

endpackage

// File: rtl/pe_lin_driver_if.sv
// Bus bundle between the driver and its environment.
//   act_*  : activation stream into the driver (valid/ready/data)
//   pe_*   : weights/activation/fire to PE_Lin and its four outputs back
//   res_*  : result stream out of the driver, res_data = {o4,o3,o2,o1}
// master = driver side, slave = environment side.
interface pe_lin_driver_if
  import pe_lin_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned OW = DefOw
) ();

  logic          act_valid;
  logic          act_ready;
  logic [DW-1:0] act_data;

  logic [DW-1:0] pe_w1, pe_w2, pe_w3, pe_w4;
  logic [DW-1:0] pe_a;
  logic          pe_fire;
  logic [OW-1:0] pe_o1, pe_o2, pe_o3, pe_o4;

  logic            res_valid;
  logic            res_ready;
  logic [4*OW-1:0] res_data;

  modport master (
    input  act_valid, act_data, pe_o1, pe_o2, pe_o3, pe_o4, res_ready,
    output act_ready, pe_w1, pe_w2, pe_w3, pe_w4, pe_a, pe_fire, res_valid, res_data
  );

  modport slave (
    output act_valid, act_data, pe_o1, pe_o2, pe_o3, pe_o4, res_ready,
    input  act_ready, pe_w1, pe_w2, pe_w3, pe_w4, pe_a, pe_fire, res_valid, res_data
  );

endinterface

// File: rtl/pe_lin_res_fifo.sv
// Result FIFO for the PE_Lin driver.
//   clk, rst       : clock, asynchronous active-high reset (empties the FIFO)
//   push_i/wdata_i : write request and data
//   pop_i          : read request (ignored when empty)
//   valid_o        : not empty; rdata_o is the head entry
//   count_o        : number of stored entries (0..Depth)
// Depth must be a power of two so the pointers wrap naturally.
module pe_lin_res_fifo #(
  parameter int unsigned Width = 48,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i && (cnt_q != '0);
  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read while the count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (cnt_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/pe_lin_driver.sv
// Job sequencer for a PE_Lin processing element.
//   clk, rst        : clock, asynchronous active-high reset
//   start, len      : one-cycle job request and number of activations (len==0 -> immediate done)
//   w1..w4          : job weights, captured when a start is accepted
//   busy, done      : job in progress, one-cycle completion pulse
//   bus (master)    : activation stream in, PE_Lin drive/outputs, result stream out
// Activations are only accepted while the result FIFO plus everything already fired can still
// hold one more result, so the PE output push never meets a full FIFO.
module pe_lin_driver
  import pe_lin_pkg::*;
#(
  parameter int unsigned DW        = DefDw,
  parameter int unsigned OW        = DefOw,
  parameter int unsigned LAT       = DefLat,
  parameter int unsigned RES_DEPTH = DefResDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            len,
  input  logic [DW-1:0]         w1,
  input  logic [DW-1:0]         w2,
  input  logic [DW-1:0]         w3,
  input  logic [DW-1:0]         w4,
  output logic                  busy,
  output logic                  done,
  pe_lin_driver_if.master       bus
);

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fire_q, fire_d;
  logic [DW-1:0]        a_q, a_d;
  logic [3:0][DW-1:0]   w_q, w_d;
  logic [7:0]           rem_q, rem_d;
  logic [LAT-1:0]       vsr_q, vsr_d;   // vsr_q[k] set: a fire happened k+1 cycles ago

  logic [4:0]               inflight;
  logic [$clog2(RES_DEPTH):0] fifo_count;
  logic                     act_ready, act_hs;

  // Fires not yet pushed, counting the one on pe_fire right now.
  always_comb begin
    inflight = 5'(fire_q);
    for (int i = 0; i < int'(LAT); i++) inflight = inflight + 5'(vsr_q[i]);
  end

  assign act_ready = (state_q == StStream) && (rem_q != '0) &&
                     ((32'(fifo_count) + 32'(inflight)) < RES_DEPTH);
  assign act_hs    = bus.act_valid && act_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start && (len != '0)) state_d = StStream;
      StStream: if (act_hs && (rem_q == 8'd1)) state_d = StDrain;
      StDrain:  if (inflight == '0) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Registered outputs and datapath
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    fire_d = act_hs;
    a_d    = act_hs ? bus.act_data : '0;
    w_d    = w_q;
    rem_d  = act_hs ? rem_q - 8'd1 : rem_q;
    vsr_d  = '0;
    vsr_d[0] = fire_q;
    for (int i = 1; i < int'(LAT); i++) vsr_d[i] = vsr_q[i-1];
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            w_d    = {w4, w3, w2, w1};
            rem_d  = len;
            busy_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (inflight == '0) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fire_q <= 1'b0;
      a_q    <= '0;
      w_q    <= '0;
      rem_q  <= '0;
      vsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      fire_q <= fire_d;
      a_q    <= a_d;
      w_q    <= w_d;
      rem_q  <= rem_d;
      vsr_q  <= vsr_d;
    end
  end

  pe_lin_res_fifo #(
    .Width (4 * OW),
    .Depth (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vsr_q[LAT-1]),
    .wdata_i ({bus.pe_o4, bus.pe_o3, bus.pe_o2, bus.pe_o1}),
    .pop_i   (bus.res_ready),
    .valid_o (bus.res_valid),
    .rdata_o (bus.res_data),
    .count_o (fifo_count)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.act_ready = act_ready;
  assign bus.pe_fire   = fire_q;
  assign bus.pe_a      = a_q;
  assign bus.pe_w1     = w_q[0];
  assign bus.pe_w2     = w_q[1];
  assign bus.pe_w3     = w_q[2];
  assign bus.pe_w4     = w_q[3];

endmodule
